sdram_timegen: RTL and testbench

- Per-bank timing generator for the SDRAM model/controller.
- Decodes the active-low SDRAM command pins (CS, RAS, CAS, WeIn) and walks a fixed command-phase state machine.
- A down-counter loaded from the programmable timing inputs (tpre, tcas, tlat, tburst, twait) times each phase.
- Exposes the current phase (StateCountOut) and remaining cycles (TimerCountOut) so datapath/bus logic can sequence data transfers.

---
 rtl/sdram_timegen_pkg.sv | 24 ++
 rtl/sdram_cmd_decode.sv | 24 ++
 rtl/sdram_timegen.sv | 126 ++++++++++++
 tb/tb_sdram_timegen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_timegen_pkg.sv
// Shared encodings for the per-bank SDRAM timing generator: phase states and decoded commands.
package sdram_timegen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_RCD    = 3'd2,
        ST_ROWACT = 3'd3,
        ST_LAT    = 3'd4,
        ST_BURST  = 3'd5,
        ST_WAIT   = 3'd6,
        ST_UNUSED = 3'd7
    } state_t;

    // Codes match the raw {CS,RAS,CAS,WeIn} pin pattern; NOP covers everything else.
    typedef enum logic [3:0] {
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b1111
    } cmd_t;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational decode of the active-low SDRAM command pins into cmd_t.
// Zero latency; no flow control.
module sdram_cmd_decode
    import sdram_timegen_pkg::*;
(
    input  logic cs_i,
    input  logic ras_i,
    input  logic cas_i,
    input  logic we_i,
    output cmd_t cmd_o
);

    always_comb begin
        cmd_o = CMD_NOP;
        case ({cs_i, ras_i, cas_i, we_i})
            4'b0010: cmd_o = CMD_PRE;
            4'b0011: cmd_o = CMD_ACT;
            4'b0100: cmd_o = CMD_WR;
            4'b0101: cmd_o = CMD_RD;
            default: cmd_o = CMD_NOP;
        endcase
    end

endmodule

// File: rtl/sdram_timegen.sv
// Per-bank SDRAM command-phase FSM with a down-counter timing each phase.
// Outputs registered, one edge after the command/expiry; En=0 freezes everything.
// Optional CmdErr pulse on ignored commands when TIMEGEN_CMD_ERR_EN is defined.
module sdram_timegen
    import sdram_timegen_pkg::*;
#(
    parameter int TW = 8,
    parameter int LW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En,
    input  logic [TW-1:0] tpre,
    input  logic [TW-1:0] tcas,
    input  logic [LW-1:0] tlat,
    input  logic [TW-1:0] tburst,
    input  logic [TW-1:0] twait,
    input  logic          CS,
    input  logic          RAS,
    input  logic          CAS,
    input  logic          WeIn,
`ifdef TIMEGEN_CMD_ERR_EN
    output logic          CmdErr,
`endif
    output logic [TW-1:0] TimerCountOut,
    output logic [2:0]    StateCountOut
);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    cmd_t          cmd;
    logic          accept;
    logic          expire;

    sdram_cmd_decode u_dec (
        .cs_i  (CS),
        .ras_i (RAS),
        .cas_i (CAS),
        .we_i  (WeIn),
        .cmd_o (cmd)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A loaded value of 0 expires on the first cycle, same as 1.
    assign expire = (timer_q <= TW'(1));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        accept  = 1'b0;
        if (En) begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (cmd == CMD_PRE) begin
                        state_d = ST_PRE;  timer_d = tpre;  accept = 1'b1;
                    end else if (cmd == CMD_ACT) begin
                        state_d = ST_RCD;  timer_d = tcas;  accept = 1'b1;
                    end
                end
                ST_ROWACT: begin
                    timer_d = '0;
                    if (cmd == CMD_RD) begin
                        state_d = ST_LAT;   timer_d = TW'(tlat); accept = 1'b1;
                    end else if (cmd == CMD_WR) begin
                        state_d = ST_BURST; timer_d = tburst;    accept = 1'b1;
                    end else if (cmd == CMD_PRE) begin
                        state_d = ST_PRE;   timer_d = tpre;      accept = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (expire) begin state_d = ST_IDLE; timer_d = '0; end
                    else        timer_d = timer_q - TW'(1);
                end
                ST_RCD: begin
                    if (expire) begin state_d = ST_ROWACT; timer_d = '0; end
                    else        timer_d = timer_q - TW'(1);
                end
                ST_LAT: begin
                    if (expire) begin state_d = ST_BURST; timer_d = tburst; end
                    else        timer_d = timer_q - TW'(1);
                end
                ST_BURST: begin
                    if (expire) begin state_d = ST_WAIT; timer_d = twait; end
                    else        timer_d = timer_q - TW'(1);
                end
                ST_WAIT: begin
                    if (expire) begin state_d = ST_ROWACT; timer_d = '0; end
                    else        timer_d = timer_q - TW'(1);
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

`ifdef TIMEGEN_CMD_ERR_EN
    logic cmd_err_q, cmd_err_d;

    always_ff @(posedge Clk) begin
        if (Rst) cmd_err_q <= 1'b0;
        else     cmd_err_q <= cmd_err_d;
    end
`endif

    always_comb begin
        TimerCountOut = timer_q;
        StateCountOut = state_q;
`ifdef TIMEGEN_CMD_ERR_EN
        cmd_err_d = En && (cmd != CMD_NOP) && !accept;
        CmdErr    = cmd_err_q;
`endif
    end

endmodule

// File: tb/tb_sdram_timegen.sv
// Directed bench for sdram_timegen: hand-computed state/timer sequences per scenario.
module tb_sdram_timegen;

    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b1111;

    logic       Clk, Rst, En;
    logic [7:0] tpre, tcas, tburst, twait;
    logic [3:0] tlat;
    logic       CS, RAS, CAS, WeIn;
    logic [7:0] TimerCountOut;
    logic [2:0] StateCountOut;
`ifdef TIMEGEN_CMD_ERR_EN
    logic       CmdErr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sdram_timegen #(.TW(8), .LW(4)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .En            (En),
        .tpre          (tpre),
        .tcas          (tcas),
        .tlat          (tlat),
        .tburst        (tburst),
        .twait         (twait),
        .CS            (CS),
        .RAS           (RAS),
        .CAS           (CAS),
        .WeIn          (WeIn),
`ifdef TIMEGEN_CMD_ERR_EN
        .CmdErr        (CmdErr),
`endif
        .TimerCountOut (TimerCountOut),
        .StateCountOut (StateCountOut)
    );

    initial begin
        Clk = 1'b0;
        forever #15 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] c);
        {CS, RAS, CAS, WeIn} = c;
    endtask

    task automatic step_chk(input string tag, input logic [2:0] st, input logic [7:0] tm);
        @(posedge Clk);
        #1;
        chk({tag, ".state"}, {5'b0, StateCountOut}, {5'b0, st});
        chk({tag, ".timer"}, TimerCountOut, tm);
    endtask

    task automatic chk_err(input string tag, input logic exp);
`ifdef TIMEGEN_CMD_ERR_EN
        chk({tag, ".cmderr"}, {7'b0, CmdErr}, {7'b0, exp});
`else
        if (exp === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        tpre = 8'd5; tcas = 8'd6; tlat = 4'd2; tburst = 8'd7; twait = 8'd1;
        Rst = 1'b1; En = 1'b1;
        set_cmd(C_PRE);

        // Reset wins over a held PRECHARGE.
        step_chk("rst0", 3'd0, 8'd0);
        chk_err("rst0", 1'b0);
        step_chk("rst1", 3'd0, 8'd0);
        Rst = 1'b0; set_cmd(C_NOP);
        step_chk("idle", 3'd0, 8'd0);

        // PRECHARGE in IDLE: five cycles in PRE.
        set_cmd(C_PRE);
        step_chk("pre_load", 3'd1, 8'd5);
        set_cmd(C_NOP);
        for (int t = 4; t >= 1; t--) step_chk("pre_cnt", 3'd1, 8'(t));
        step_chk("pre_done", 3'd0, 8'd0);

        // ACTIVATE then WRITE.
        set_cmd(C_ACT);
        step_chk("act_load", 3'd2, 8'd6);
        set_cmd(C_NOP);
        for (int t = 5; t >= 1; t--) step_chk("rcd_cnt", 3'd2, 8'(t));
        step_chk("rowact", 3'd3, 8'd0);
        set_cmd(C_WR);
        step_chk("wr_load", 3'd5, 8'd7);
        set_cmd(C_NOP);
        for (int t = 6; t >= 1; t--) step_chk("wburst_cnt", 3'd5, 8'(t));
        step_chk("wwait", 3'd6, 8'd1);
        step_chk("wrow", 3'd3, 8'd0);

        // PRECHARGE from ROWACT, then ACTIVATE + READ.
        set_cmd(C_PRE);
        step_chk("row_pre", 3'd1, 8'd5);
        set_cmd(C_NOP);
        for (int t = 4; t >= 1; t--) step_chk("pre2_cnt", 3'd1, 8'(t));
        step_chk("pre2_done", 3'd0, 8'd0);
        set_cmd(C_ACT);
        step_chk("act2", 3'd2, 8'd6);
        set_cmd(C_NOP);
        for (int t = 5; t >= 1; t--) step_chk("rcd2_cnt", 3'd2, 8'(t));
        step_chk("rowact2", 3'd3, 8'd0);
        set_cmd(C_RD);
        step_chk("lat2", 3'd4, 8'd2);
        set_cmd(C_NOP);
        step_chk("lat1", 3'd4, 8'd1);
        step_chk("rburst_load", 3'd5, 8'd7);
        for (int t = 6; t >= 1; t--) step_chk("rburst_cnt", 3'd5, 8'(t));
        step_chk("rwait", 3'd6, 8'd1);
        step_chk("rrow", 3'd3, 8'd0);
        set_cmd(C_PRE);
        step_chk("row_pre2", 3'd1, 8'd5);
        set_cmd(C_NOP);
        for (int t = 4; t >= 1; t--) step_chk("pre3_cnt", 3'd1, 8'(t));
        step_chk("pre3_done", 3'd0, 8'd0);

        // En dropped mid-BURST at timer 4; a READ during BURST is ignored.
        set_cmd(C_ACT);
        step_chk("act3", 3'd2, 8'd6);
        set_cmd(C_NOP);
        for (int t = 5; t >= 1; t--) step_chk("rcd3_cnt", 3'd2, 8'(t));
        step_chk("rowact3", 3'd3, 8'd0);
        set_cmd(C_WR);
        step_chk("wr3", 3'd5, 8'd7);
        set_cmd(C_NOP);
        for (int t = 6; t >= 4; t--) step_chk("wr3_cnt", 3'd5, 8'(t));
        En = 1'b0; set_cmd(C_RD);
        for (int i = 0; i < 3; i++) begin
            step_chk("en_hold", 3'd5, 8'd4);
            chk_err("en_hold", 1'b0);
        end
        En = 1'b1;
        step_chk("resume_rd", 3'd5, 8'd3);
        chk_err("rd_in_burst", 1'b1);
        set_cmd(C_NOP);
        step_chk("resume2", 3'd5, 8'd2);
        chk_err("err_clear", 1'b0);
        step_chk("resume1", 3'd5, 8'd1);
        step_chk("wait3", 3'd6, 8'd1);
        step_chk("row3", 3'd3, 8'd0);

        // Timing inputs sampled at load: zero latency and zero precharge last one cycle.
        tlat = 4'd0; tpre = 8'd0;
        set_cmd(C_RD);
        step_chk("lat0", 3'd4, 8'd0);
        set_cmd(C_NOP);
        tlat = 4'd9;
        step_chk("lat0_exp", 3'd5, 8'd7);
        for (int t = 6; t >= 1; t--) step_chk("b4_cnt", 3'd5, 8'(t));
        step_chk("wait4", 3'd6, 8'd1);
        step_chk("row4", 3'd3, 8'd0);
        set_cmd(C_PRE);
        step_chk("pre0", 3'd1, 8'd0);
        set_cmd(C_NOP);
        step_chk("pre0_exp", 3'd0, 8'd0);

        // READ in IDLE is ignored.
        set_cmd(C_RD);
        step_chk("rd_idle", 3'd0, 8'd0);
        chk_err("rd_idle", 1'b1);
        set_cmd(C_NOP);
        step_chk("idle_end", 3'd0, 8'd0);
        chk_err("idle_end", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
